// File: rtl/crypt_pkg.sv
// Shared definitions for the encrypted-word format: field positions, cipher
// selects and the key/rotation helpers used by both encrypt and decrypt paths.
package crypt_pkg;

    localparam int WORD_W  = 78;
    localparam int K6_HI   = 77;
    localparam int K6_LO   = 72;
    localparam int K11_HI  = 71;
    localparam int K11_LO  = 61;
    localparam int PAR_BIT = 60;
    localparam int DATA_HI = 59;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        SEL_XOR = 2'd0,
        SEL_ROT = 2'd1,
        SEL_ADD = 2'd2,
        SEL_REV = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [59:0] keystream(input logic [4:0] k6_lo, input logic [10:0] k11);
        return {k11, k11, k11, k11, k11, k6_lo};
    endfunction

    function automatic logic [59:0] bitrev60(input logic [59:0] v);
        logic [59:0] r;
        for (int i = 0; i < 60; i++) begin
            r[i] = v[59-i];
        end
        return r;
    endfunction

    // k6 spans 0..63, but only 0..59 is a meaningful rotation of a 60-bit ring
    function automatic logic [5:0] rot_amount(input logic [5:0] k6);
        return (k6 >= 6'd60) ? (k6 - 6'd60) : k6;
    endfunction

endpackage

// File: rtl/decrypt_recover.sv
// Combinational plaintext recovery from an already-unrotated cipher word,
// keystream and cipher select; also reports the plaintext parity.
module decrypt_recover
    import crypt_pkg::*;
(
    input  logic [59:0] i_cipher,
    input  logic [59:0] i_key,
    input  sel_e        i_sel,
    output logic [59:0] o_plain,
    output logic        o_parity
);

    logic [59:0] w_xor;

    assign w_xor = i_cipher ^ i_key;

    always_comb begin
        o_plain = w_xor;
        case (i_sel)
            SEL_XOR: o_plain = w_xor;
            SEL_ROT: o_plain = w_xor;
            SEL_ADD: o_plain = i_cipher - i_key;
            SEL_REV: o_plain = bitrev60(w_xor);
            default: o_plain = w_xor;
        endcase
    end

    assign o_parity = ^o_plain;

endmodule

// File: rtl/decrypter.sv
// Receive-side decrypter: accepts a 78-bit encrypted word, undoes the rotation
// one bit per cycle when needed, and holds the plaintext until consumed.
module decrypter
    import crypt_pkg::*;
#(
    parameter int DATA_W       = 60,
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] data_encrypted,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_decrypted,
    output logic              parity_error
);

    if (DATA_W != 60) begin : g_bad_width
        $error("decrypter: only DATA_W=60 is supported");
    end

    state_e      r_state;
    state_e      w_state_nxt;
    logic [59:0] r_c;
    logic [5:0]  r_k6;
    logic [10:0] r_k11;
    logic        r_par;
    logic [5:0]  r_cnt;
    logic [59:0] r_data;
    logic        r_perr;

    sel_e        w_sel;
    logic [5:0]  w_r;
    logic [59:0] w_key;
    logic        w_rot_more;
    logic        w_load;
    logic        w_step;
    logic        w_capture;
    logic [59:0] w_plain;
    logic        w_plain_par;

    assign w_sel      = sel_e'(r_k6[1:0]);
    assign w_r        = rot_amount(r_k6);
    assign w_key      = keystream(r_k6[4:0], r_k11);
    assign w_rot_more = (w_sel == SEL_ROT) && (r_cnt != w_r);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)    w_state_nxt = ST_RUN;
            ST_RUN:  if (!w_rot_more) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        w_load    = (r_state == ST_IDLE) && in_valid;
        w_step    = (r_state == ST_RUN) && w_rot_more;
        w_capture = (r_state == ST_RUN) && !w_rot_more;
    end

    decrypt_recover u_recover (
        .i_cipher (r_c),
        .i_key    (w_key),
        .i_sel    (w_sel),
        .o_plain  (w_plain),
        .o_parity (w_plain_par)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_c    <= '0;
            r_k6   <= '0;
            r_k11  <= '0;
            r_par  <= 1'b0;
            r_cnt  <= '0;
            r_data <= '0;
            r_perr <= 1'b0;
        end else begin
            if (w_load) begin
                r_c   <= data_encrypted[DATA_HI:DATA_LO];
                r_k6  <= data_encrypted[K6_HI:K6_LO];
                r_k11 <= data_encrypted[K11_HI:K11_LO];
                r_par <= data_encrypted[PAR_BIT];
                r_cnt <= '0;
            end
            // right-rotate one position per cycle to undo the sender's left rotate
            if (w_step) begin
                r_c   <= {r_c[0], r_c[59:1]};
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_capture) begin
                r_data <= w_plain;
                r_perr <= CHECK_PARITY ? (w_plain_par != r_par) : 1'b0;
            end
        end
    end

    assign data_decrypted = r_data;
    assign parity_error   = r_perr;

endmodule

// File: tb/tb_decrypter.sv
// Self-checking bench for decrypter: directed spec cases plus randomized words
// checked against a plain-arithmetic reference of the cipher rules.
module tb_decrypter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [77:0] data_encrypted;
    logic        out_valid;
    logic        out_ready;
    logic [59:0] data_decrypted;
    logic        parity_error;

    logic        in_ready_np;
    logic        out_valid_np;
    logic [59:0] data_decrypted_np;
    logic        parity_error_np;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    decrypter #(.DATA_W(60), .CHECK_PARITY(1'b1)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_encrypted (data_encrypted),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_decrypted (data_decrypted),
        .parity_error   (parity_error)
    );

    decrypter #(.DATA_W(60), .CHECK_PARITY(1'b0)) dut_np (
        .Clk            (Clk),
        .Rst            (Rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready_np),
        .data_encrypted (data_encrypted),
        .out_valid      (out_valid_np),
        .out_ready      (out_ready),
        .data_decrypted (data_decrypted_np),
        .parity_error   (parity_error_np)
    );

    // ---------------- reference model ----------------
    function automatic logic [77:0] mk_word(logic [5:0] k6, logic [10:0] k11, logic par, logic [59:0] c);
        return {k6, k11, par, c};
    endfunction

    function automatic int m_rot(logic [77:0] w);
        int k6;
        k6 = int'(w[77:72]);
        return (k6 >= 60) ? k6 - 60 : k6;
    endfunction

    function automatic int m_sel(logic [77:0] w);
        return int'(w[77:72]) % 4;
    endfunction

    function automatic logic [59:0] m_plain(logic [77:0] w);
        logic [59:0]  c, k, x, p;
        logic [119:0] dbl;
        logic [10:0]  k11;
        k11 = w[71:61];
        c   = w[59:0];
        k   = {k11, k11, k11, k11, k11, w[76:72]};
        case (m_sel(w))
            0: p = c ^ k;
            1: begin
                dbl = {c, c} >> m_rot(w);
                x   = dbl[59:0];
                p   = x ^ k;
            end
            2: p = c - k;
            default: begin
                x = c ^ k;
                for (int i = 0; i < 60; i++) p[i] = x[59-i];
            end
        endcase
        return p;
    endfunction

    function automatic logic m_perr(logic [77:0] w);
        logic [59:0] p;
        p = m_plain(w);
        return (^p) != w[60];
    endfunction

    function automatic int m_lat(logic [77:0] w);
        return (m_sel(w) == 1) ? m_rot(w) + 1 : 1;
    endfunction

    function automatic logic [77:0] rnd_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[77:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic accept(input logic [77:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_wait: in_ready=%b required 1 after %0d cycles", in_ready, n);
        end
        in_valid       = 1'b1;
        data_encrypted = w;
        tick();
        in_valid       = 1'b0;
        data_encrypted = rnd_word();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic xact(input logic [77:0] w, output int lat, output logic [59:0] d,
                        output logic pe, output logic [59:0] d_np, output logic pe_np);
        accept(w);
        wait_valid(lat);
        d     = data_decrypted;
        pe    = parity_error;
        d_np  = data_decrypted_np;
        pe_np = parity_error_np;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_encrypted = '0;
        repeat (2) tick();
        n_vec += 4;
        if (in_ready !== 1'b1)     begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)    begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (data_decrypted !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_decrypted); end
        if (parity_error !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_error); end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_xor();
        int lat; logic [59:0] d, dn; logic pe, pen;
        xact(mk_word(6'd0, 11'h7FF, 1'b0, 60'hFFFFFFFFFFFFFE0), lat, d, pe, dn, pen);
        n_vec += 3;
        if (d !== 60'h0)   begin n_err++; $display("FAIL xor_data: got %h want 0", d); end
        if (pe !== 1'b0)   begin n_err++; $display("FAIL xor_perr: got %b want 0", pe); end
        if (lat != 1)      begin n_err++; $display("FAIL xor_latency: got %0d want 1", lat); end
    endtask

    task automatic test_rotate();
        int lat; logic [59:0] d, dn; logic pe, pen;
        xact(mk_word(6'd61, 11'h000, 1'b1, 60'h38), lat, d, pe, dn, pen);
        n_vec += 3;
        if (d !== 60'h1)   begin n_err++; $display("FAIL rot_data: got %h want 1", d); end
        if (pe !== 1'b0)   begin n_err++; $display("FAIL rot_perr: got %b want 0", pe); end
        if (lat != 2)      begin n_err++; $display("FAIL rot_latency: got %0d want 2", lat); end
    endtask

    task automatic test_add_wrap();
        int lat; logic [59:0] d, dn; logic pe, pen;
        xact(mk_word(6'd2, 11'h000, 1'b0, 60'h1), lat, d, pe, dn, pen);
        n_vec += 3;
        if (d !== 60'hFFFFFFFFFFFFFFF) begin n_err++; $display("FAIL add_data: got %h want fffffffffffffff", d); end
        if (pe !== 1'b0)               begin n_err++; $display("FAIL add_perr: got %b want 0", pe); end
        if (lat != 1)                  begin n_err++; $display("FAIL add_latency: got %0d want 1", lat); end
    endtask

    task automatic test_parity();
        int lat; logic [59:0] d, dn; logic pe, pen;
        xact(mk_word(6'd0, 11'h7FF, 1'b1, 60'hFFFFFFFFFFFFFE0), lat, d, pe, dn, pen);
        n_vec += 4;
        if (d !== 60'h0)  begin n_err++; $display("FAIL par_data: got %h want 0", d); end
        if (pe !== 1'b1)  begin n_err++; $display("FAIL par_perr: got %b want 1", pe); end
        if (dn !== 60'h0) begin n_err++; $display("FAIL par_nochk_data: got %h want 0", dn); end
        if (pen !== 1'b0) begin n_err++; $display("FAIL par_nochk_perr: got %b want 0", pen); end
    endtask

    task automatic test_backpressure();
        logic [77:0] w;
        logic [59:0] exp_d;
        int lat;
        w = mk_word(6'd3, 11'($urandom()), 1'($urandom()), {28'($urandom()), 32'($urandom())});
        exp_d = m_plain(w);
        accept(w);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec += 3;
            if (out_valid !== 1'b1)    begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            if (data_decrypted !== exp_d) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, data_decrypted, exp_d); end
            if (in_ready !== 1'b0)     begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [77:0] w;
        int lat; logic [59:0] d, dn; logic pe, pen;
        accept(mk_word(6'd57, 11'($urandom()), 1'b0, {28'($urandom()), 32'($urandom())}));
        repeat (10) tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_not_done: got %b want 0", out_valid); end
        #2 Rst = 1'b1;
        #1;
        n_vec += 4;
        if (out_valid !== 1'b0)    begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (data_decrypted !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", data_decrypted); end
        if (in_ready !== 1'b1)     begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        if (parity_error !== 1'b0) begin n_err++; $display("FAIL mid_rst_perr: got %b want 0", parity_error); end
        tick();
        Rst = 1'b0;
        tick();
        w = rnd_word();
        xact(w, lat, d, pe, dn, pen);
        n_vec += 2;
        if (d !== m_plain(w)) begin n_err++; $display("FAIL mid_after_data: got %h want %h", d, m_plain(w)); end
        if (pe !== m_perr(w)) begin n_err++; $display("FAIL mid_after_perr: got %b want %b", pe, m_perr(w)); end
    endtask

    task automatic test_random();
        logic [77:0] w;
        int lat; logic [59:0] d, dn; logic pe, pen;
        for (int i = 0; i < 40; i++) begin
            w = rnd_word();
            xact(w, lat, d, pe, dn, pen);
            n_vec += 5;
            if (d !== m_plain(w)) begin n_err++; $display("FAIL rnd_data[%0d] sel=%0d: got %h want %h", i, m_sel(w), d, m_plain(w)); end
            if (pe !== m_perr(w)) begin n_err++; $display("FAIL rnd_perr[%0d]: got %b want %b", i, pe, m_perr(w)); end
            if (lat != m_lat(w))  begin n_err++; $display("FAIL rnd_latency[%0d] k6=%0d: got %0d want %0d", i, w[77:72], lat, m_lat(w)); end
            if (dn !== m_plain(w)) begin n_err++; $display("FAIL rnd_nochk_data[%0d]: got %h want %h", i, dn, m_plain(w)); end
            if (pen !== 1'b0)     begin n_err++; $display("FAIL rnd_nochk_perr[%0d]: got %b want 0", i, pen); end
        end
    endtask

    task automatic test_back_to_back();
        logic [77:0] w;
        logic [59:0] d;
        logic pe, got;
        int n, exp_n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w = rnd_word();
            data_encrypted = w;
            tick();
            n = 0; got = 1'b0; d = '0; pe = 1'b0;
            while (in_ready !== 1'b1 && n < 200) begin
                if (out_valid === 1'b1) begin
                    d = data_decrypted; pe = parity_error; got = 1'b1;
                end
                tick();
                n++;
            end
            if (i == 11) in_valid = 1'b0;
            exp_n = 2 + ((m_sel(w) == 1) ? m_rot(w) : 0);
            n_vec += 4;
            if (got !== 1'b1)     begin n_err++; $display("FAIL b2b_seen[%0d]: got %b want 1", i, got); end
            if (d !== m_plain(w)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d, m_plain(w)); end
            if (pe !== m_perr(w)) begin n_err++; $display("FAIL b2b_perr[%0d]: got %b want %b", i, pe, m_perr(w)); end
            if (n != exp_n)       begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, n, exp_n); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_xor();
        test_rotate();
        test_add_wrap();
        test_parity();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
